// File: rtl/tdm_demux_1_to_4.sv
// tdm_demux_1_to_4: receive end of a 4-slot time-division multiplexed link.
// A serial stream of W-bit beats is tracked slot by slot. Slot 0 is marked by
// frame_sync. Slots 0..2 are parked in a shadow register file, and the slot-3
// beat publishes all four channels on dout at once, together with a one-cycle
// dout_valid pulse. A framing violation raises a one-cycle sync_err pulse.
module tdm_demux_1_to_4 #(
    parameter int W = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   din,
    input  logic           din_valid,
    input  logic           frame_sync,
    output logic [4*W-1:0] dout,
    output logic           dout_valid,
    output logic [1:0]     slot,
    output logic           locked,
    output logic           sync_err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Effect of one cycle on the datapath. It is decided by the FSM and
    // carried out by the output logic.
    typedef enum logic [2:0] {
        ACT_IDLE,   // no beat, or a beat discarded while hunting
        ACT_START,  // slot-0 beat with sync: open a new frame
        ACT_STORE,  // slot-1/2 beat: park it in the shadow file
        ACT_EMIT,   // slot-3 beat: publish the complete frame
        ACT_LOSE,   // slot-0 beat without sync: drop lock
        ACT_RESYNC  // sync before slot 0: drop the partial frame and restart
    } action_t;

    state_t         state;
    state_t         state_nxt;
    action_t        action;

    logic [1:0]     slot_nxt;
    logic [W-1:0]   shadow [3];
    logic           shadow_we;
    logic [1:0]     shadow_sel;

    logic [4*W-1:0] dout_nxt;
    logic           dout_valid_nxt;
    logic           sync_err_nxt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
        end else begin
            // NOTE: use non-blocking (<=) for every flop so that all registers
            // sample pre-edge values, whatever order the blocks run in.
            state <= state_nxt;
        end
    end

    // Next-state logic: classify the accepted beat and pick the next state.
    always_comb begin
        // NOTE: give every output of a combinational block a default first.
        // Any path that leaves one unassigned would infer a latch.
        state_nxt = state;
        action    = ACT_IDLE;

        if (din_valid) begin
            case (state)
                HUNT: begin
                    if (frame_sync) begin
                        action    = ACT_START;
                        state_nxt = LOCKED;
                    end
                end

                LOCKED: begin
                    if (slot == 2'd0) begin
                        if (frame_sync) begin
                            action = ACT_START;
                        end else begin
                            action    = ACT_LOSE;
                            state_nxt = HUNT;
                        end
                    end else if (frame_sync) begin
                        action = ACT_RESYNC;
                    end else if (slot == 2'd3) begin
                        action = ACT_EMIT;
                    end else begin
                        action = ACT_STORE;
                    end
                end

                default: begin
                    state_nxt = HUNT;
                end
            endcase
        end
    end

    // Output logic: compute the datapath updates for the chosen action.
    always_comb begin
        slot_nxt       = slot;
        shadow_we      = 1'b0;
        shadow_sel     = 2'd0;
        dout_nxt       = dout;
        dout_valid_nxt = 1'b0;
        sync_err_nxt   = 1'b0;

        case (action)
            ACT_START: begin
                shadow_we  = 1'b1;
                shadow_sel = 2'd0;
                slot_nxt   = 2'd1;
            end

            ACT_RESYNC: begin
                // The early-sync beat becomes slot 0 of the new frame.
                shadow_we    = 1'b1;
                shadow_sel   = 2'd0;
                slot_nxt     = 2'd1;
                sync_err_nxt = 1'b1;
            end

            ACT_STORE: begin
                shadow_we  = 1'b1;
                shadow_sel = slot;
                slot_nxt   = slot + 2'd1;
            end

            ACT_EMIT: begin
                // The slot-3 beat goes straight to dout, so all four channels
                // change on the same edge.
                dout_nxt       = {din, shadow[2], shadow[1], shadow[0]};
                dout_valid_nxt = 1'b1;
                slot_nxt       = 2'd0;
            end

            ACT_LOSE: begin
                sync_err_nxt = 1'b1;
                slot_nxt     = 2'd0;
            end

            default: begin
            end
        endcase
    end

    // Shadow file: holds slots 0..2 of the frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this small storage array is reset on purpose. Reset must
            // clear it, so it maps to flops rather than to a RAM, which could
            // not be cleared in one cycle.
            for (int i = 0; i < 3; i++) begin
                shadow[i] <= '0;
            end
        end else if (shadow_we) begin
            shadow[shadow_sel] <= din;
        end
    end

    // Slot counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot       <= 2'd0;
            dout       <= '0;
            dout_valid <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            slot       <= slot_nxt;
            dout       <= dout_nxt;
            dout_valid <= dout_valid_nxt;
            sync_err   <= sync_err_nxt;
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux_1_to_4.sv
// Testbench for tdm_demux_1_to_4 with W=4.
// The stimulus process queues the expected dout_valid and sync_err events.
// A negedge monitor pops and compares an entry each time the DUT pulses.
module tb_tdm_demux_1_to_4;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [W-1:0]   din;
    logic           din_valid;
    logic           frame_sync;
    logic [4*W-1:0] dout;
    logic           dout_valid;
    logic [1:0]     slot;
    logic           locked;
    logic           sync_err;

    tdm_demux_1_to_4 #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .slot       (slot),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           is_err;
        logic [4*W-1:0] data;
    } exp_t;

    exp_t exp_q[$];

    int checks           = 0;
    int errors           = 0;
    int cycle            = 0;
    int last_valid_cycle = 0;
    int prev_valid_cycle = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic expect_dout(input logic [4*W-1:0] data);
        exp_t e;
        e.is_err = 1'b0;
        e.data   = data;
        exp_q.push_back(e);
    endtask

    task automatic expect_err();
        exp_t e;
        e.is_err = 1'b1;
        e.data   = '0;
        exp_q.push_back(e);
    endtask

    // Drive one beat at a negedge. The next posedge accepts it, and the task
    // returns at the following negedge, when the outputs show the result.
    task automatic beat(input logic [W-1:0] d, input logic s);
        din        = d;
        frame_sync = s;
        din_valid  = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: compare every output pulse with the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        cycle++;
        if (dout_valid || sync_err) begin
            check("pulse_overlap", 32'(dout_valid & sync_err), 32'd0);
            if (dout_valid) begin
                prev_valid_cycle = last_valid_cycle;
                last_valid_cycle = cycle;
            end
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got dout_valid=%0b sync_err=%0b, expected no pulse",
                         dout_valid, sync_err);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", 32'(sync_err), 32'(e.is_err));
                if (!e.is_err) begin
                    check("dout_frame", 32'(dout), 32'(e.data));
                end
            end
        end
    end

    // Watchdog, so that a stuck run still ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state.
        check("rst_dout",       32'(dout),       32'h0);
        check("rst_dout_valid", 32'(dout_valid), 32'h0);
        check("rst_sync_err",   32'(sync_err),   32'h0);
        check("rst_locked",     32'(locked),     32'h0);
        check("rst_slot",       32'(slot),       32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame A,B,C,D, then a second frame back to back.
        check("t1_slot_a", 32'(slot), 32'd0);
        beat(4'hA, 1'b1);
        check("t1_slot_b",   32'(slot),   32'd1);
        check("t1_locked_b", 32'(locked), 32'd1);
        beat(4'hB, 1'b0);
        check("t1_slot_c", 32'(slot), 32'd2);
        beat(4'hC, 1'b0);
        check("t1_slot_d",   32'(slot),   32'd3);
        check("t1_locked_d", 32'(locked), 32'd1);
        expect_dout(16'hDCBA);
        beat(4'hD, 1'b0);
        check("t1_slot_wrap", 32'(slot), 32'd0);
        beat(4'h1, 1'b1);
        check("t1_valid_one_cycle", 32'(dout_valid), 32'd0);
        check("t1_dout_hold",       32'(dout),       32'hDCBA);
        beat(4'h2, 1'b0);
        beat(4'h3, 1'b0);
        expect_dout(16'h4321);
        beat(4'h4, 1'b0);
        idle(1);
        check("t1_dout_hold2",     32'(dout),                               32'h4321);
        check("t1_frame_spacing",  32'(last_valid_cycle - prev_valid_cycle), 32'd4);
        check("t1_queue_empty",    32'(exp_q.size()),                        32'd0);

        // Missing sync at slot 0: drop lock, keep dout.
        expect_err();
        beat(4'h3, 1'b0);
        check("t4_locked", 32'(locked), 32'd0);
        check("t4_slot",   32'(slot),   32'd0);
        check("t4_dout",   32'(dout),   32'h4321);
        idle(1);
        check("t4_err_one_cycle", 32'(sync_err), 32'd0);

        // In HUNT, unsynced beats are discarded silently.
        beat(4'h1, 1'b0);
        beat(4'h2, 1'b0);
        check("t2_locked", 32'(locked), 32'd0);
        check("t2_slot",   32'(slot),   32'd0);
        check("t2_dout",   32'(dout),   32'h4321);
        beat(4'h5, 1'b1);
        beat(4'h6, 1'b0);
        beat(4'h7, 1'b0);
        expect_dout(16'h8765);
        beat(4'h8, 1'b0);
        idle(1);
        check("t2_dout_final",  32'(dout),          32'h8765);
        check("t2_queue_empty", 32'(exp_q.size()),  32'd0);

        // Early sync at slot 2 restarts the frame from the sync beat.
        beat(4'h1, 1'b1);
        beat(4'h2, 1'b0);
        expect_err();
        beat(4'h9, 1'b1);
        check("t3_slot",   32'(slot),   32'd1);
        check("t3_locked", 32'(locked), 32'd1);
        check("t3_dout",   32'(dout),   32'h8765);
        beat(4'hA, 1'b0);
        beat(4'hB, 1'b0);
        expect_dout(16'hCBA9);
        beat(4'hC, 1'b0);
        idle(1);
        check("t3_dout_final", 32'(dout), 32'hCBA9);

        // Idle gaps in the middle of a frame keep lock and hold dout.
        beat(4'h4, 1'b1);
        idle(3);
        check("t5_gap_dout",   32'(dout),       32'hCBA9);
        check("t5_gap_valid",  32'(dout_valid), 32'd0);
        check("t5_gap_slot",   32'(slot),       32'd1);
        check("t5_gap_locked", 32'(locked),     32'd1);
        beat(4'h5, 1'b0);
        idle(1);
        check("t5_gap2_slot", 32'(slot), 32'd2);
        beat(4'h6, 1'b0);
        expect_dout(16'h7654);
        beat(4'h7, 1'b0);
        idle(1);
        check("t5_dout_final",  32'(dout),         32'h7654);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset between clock edges in the middle of a frame.
        beat(4'h1, 1'b1);
        beat(4'h2, 1'b0);
        check("t6_slot_pre", 32'(slot), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_dout",   32'(dout),   32'h0);
        check("t6_async_locked", 32'(locked), 32'd0);
        check("t6_async_slot",   32'(slot),   32'd0);
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        beat(4'hF, 1'b0);
        check("t6_nosync_locked", 32'(locked), 32'd0);
        check("t6_nosync_slot",   32'(slot),   32'd0);
        check("t6_nosync_dout",   32'(dout),   32'h0);
        beat(4'hE, 1'b1);
        beat(4'hD, 1'b0);
        beat(4'hC, 1'b0);
        expect_dout(16'hBCDE);
        beat(4'hB, 1'b0);
        idle(2);
        check("t6_dout_final",  32'(dout),         32'hBCDE);
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
